fifo_stream_adapter: RTL and testbench



---
 rtl/fifo_stream_pkg.sv | 10 +
 rtl/fifo_stream_adapter_if.sv | 24 ++
 rtl/stream_reg_buffer.sv | 72 +++++++
 rtl/fifo_stream_adapter.sv | 103 ++++++++++
 tb/tb_fifo_stream_adapter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_stream_pkg.sv
// Shared constants and helpers for the FIFO-to-stream adapter and its buffer.
package fifo_stream_pkg;

    localparam int BEAT_CNT_W = 32;

    function automatic int lvl_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_stream_adapter_if.sv
// Bundles the FIFO read port and the valid/ready stream port seen by the adapter.
interface fifo_stream_adapter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic                  fifo_valid;
    logic                  fifo_shift_out;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;

    // The adapter masters the stream and pops the FIFO.
    modport master (
        input  fifo_empty, fifo_dout, fifo_valid, m_ready,
        output fifo_shift_out, m_data, m_valid
    );

    // The environment: the FIFO plus the stream consumer.
    modport slave (
        output fifo_empty, fifo_dout, fifo_valid, m_ready,
        input  fifo_shift_out, m_data, m_valid
    );
endinterface

// File: rtl/stream_reg_buffer.sv
// Circular register buffer with head/tail pointers; clr empties it in one cycle.
module stream_reg_buffer
    import fifo_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BUF_DEPTH  = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clr,
    input  logic                        wr_en,
    input  logic [DATA_WIDTH-1:0]       wr_data,
    input  logic                        rd_en,
    output logic [DATA_WIDTH-1:0]       rd_data,
    output logic [lvl_w(BUF_DEPTH)-1:0] level
);
    localparam int LW = lvl_w(BUF_DEPTH);
    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(BUF_DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [BUF_DEPTH];
    logic [PW-1:0]         head_q, head_d;
    logic [PW-1:0]         tail_q, tail_d;
    logic [LW-1:0]         level_q, level_d;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        level_d = level_q;
        if (clr) begin
            head_d  = '0;
            tail_d  = '0;
            level_d = '0;
        end else begin
            if (wr_en) begin
                mem_d[tail_q] = wr_data;
                tail_d        = ptr_inc(tail_q);
            end
            if (rd_en) head_d = ptr_inc(head_q);
            // A simultaneous write and read leaves the occupancy unchanged.
            case ({wr_en, rd_en})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            level_q <= '0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            level_q <= level_d;
        end
    end

    assign rd_data = mem_q[head_q];
    assign level   = level_q;

endmodule

// File: rtl/fifo_stream_adapter.sv
// Reads a synchronous FIFO and re-presents its words on a valid/ready stream,
// with credit-based pop issue, flush, a beat counter and a sticky protocol error.
module fifo_stream_adapter
    import fifo_stream_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1,
    parameter int BUF_DEPTH    = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    fifo_stream_adapter_if.master       bus,
    input  logic                        flush,
    output logic [BEAT_CNT_W-1:0]       beat_count,
    output logic [lvl_w(BUF_DEPTH)-1:0] buf_level,
    output logic                        protocol_err
);
    localparam int LW = lvl_w(BUF_DEPTH);

    logic [LW-1:0]         level;
    logic [DATA_WIDTH-1:0] head_data;
    logic [LW:0]           occupancy;
    logic                  valid, pop, shift, wr_en, bad_valid;
    logic                  en_q, en_d;
    logic                  inflight_q, inflight_d;
    logic                  drop_q, drop_d;
    logic                  err_q, err_d;
    logic [BEAT_CNT_W-1:0] beat_q, beat_d;

    assign valid = (level != '0);
    assign pop   = valid && bus.m_ready;

    // Words already in the buffer or on their way count against the space;
    // a beat leaving this cycle frees its slot immediately.
    assign occupancy = {1'b0, level} + (LW+1)'(inflight_q) - (LW+1)'(pop);
    assign shift     = en_q && !bus.fifo_empty && !flush
                       && (occupancy < (LW+1)'(BUF_DEPTH));

    if (BUF_DEPTH < 2) begin : g_bad_depth
        $error("fifo_stream_adapter: BUF_DEPTH must be at least 2");
    end

    if (READ_LATENCY == 1) begin : g_lat1
        assign inflight_d = shift;
        assign wr_en      = bus.fifo_valid && inflight_q && !drop_q && !flush;
        assign bad_valid  = bus.fifo_valid && !inflight_q && !drop_q;
    end else if (READ_LATENCY == 0) begin : g_lat0
        assign inflight_d = 1'b0;
        assign wr_en      = shift && bus.fifo_valid;
        assign bad_valid  = bus.fifo_valid && !shift && !drop_q;
    end else begin : g_bad_lat
        $error("fifo_stream_adapter: READ_LATENCY must be 0 or 1");
    end

    always_comb begin
        en_d   = 1'b1;
        // A word popped just before a flush lands one cycle late and is discarded.
        drop_d = flush && inflight_q;
        err_d  = err_q || bad_valid;
        beat_d = beat_q + BEAT_CNT_W'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q       <= 1'b0;
            inflight_q <= 1'b0;
            drop_q     <= 1'b0;
            err_q      <= 1'b0;
            beat_q     <= '0;
        end else begin
            en_q       <= en_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            err_q      <= err_d;
            beat_q     <= beat_d;
        end
    end

    stream_reg_buffer #(
        .DATA_WIDTH(DATA_WIDTH),
        .BUF_DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (flush),
        .wr_en  (wr_en),
        .wr_data(bus.fifo_dout),
        .rd_en  (pop),
        .rd_data(head_data),
        .level  (level)
    );

    assign bus.fifo_shift_out = shift;
    assign bus.m_valid        = valid;
    assign bus.m_data         = head_data;
    assign beat_count         = beat_q;
    assign buf_level          = level;
    assign protocol_err       = err_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(wr_en && (level == LW'(BUF_DEPTH)) && !pop));

endmodule

// File: tb/tb_fifo_stream_adapter.sv
// Bench for fifo_stream_adapter: latency-1 and latency-0 instances fed by queue-based FIFO models.
module tb_fifo_stream_adapter;
    import fifo_stream_pkg::*;

    localparam int DW = 32;
    localparam int BD = 2;
    localparam int LW = lvl_w(BD);

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    fifo_stream_adapter_if #(.DATA_WIDTH(DW)) if1 ();
    fifo_stream_adapter_if #(.DATA_WIDTH(DW)) if0 ();

    logic          flush1 = 1'b0, flush0 = 1'b0, force0 = 1'b0;
    logic [31:0]   bc1, bc0;
    logic [LW-1:0] lv1, lv0;
    logic          pe1, pe0;

    // A zero-latency FIFO answers a pop in the same cycle.
    assign if0.fifo_valid = if0.fifo_shift_out | force0;

    fifo_stream_adapter #(.DATA_WIDTH(DW), .READ_LATENCY(1), .BUF_DEPTH(BD)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(if1.master), .flush(flush1),
        .beat_count(bc1), .buf_level(lv1), .protocol_err(pe1));
    fifo_stream_adapter #(.DATA_WIDTH(DW), .READ_LATENCY(0), .BUF_DEPTH(BD)) u0 (
        .clk(clk), .rst_n(rst_n), .bus(if0.master), .flush(flush0),
        .beat_count(bc0), .buf_level(lv0), .protocol_err(pe0));

    logic [DW-1:0] q1[$], q0[$], pend1[$], pend0[$];
    logic [DW-1:0] got1[$], want1[$], got0[$], want0[$];
    int shift_cyc1[$], beat_cyc1[$], shift_cyc0[$], beat_cyc0[$];
    int cyc = 0, maxout1 = 0, maxout0 = 0;
    int checks = 0, failures = 0;

    task automatic clear_rec();
        got1.delete(); want1.delete(); got0.delete(); want0.delete();
        shift_cyc1.delete(); beat_cyc1.delete(); shift_cyc0.delete(); beat_cyc0.delete();
        pend1.delete(); pend0.delete();
        maxout1 = 0; maxout0 = 0;
    endtask

    // One clock cycle: present FIFO state, observe handshakes, advance the models.
    // Words handed out and not yet accepted are pending; a flush discards them all.
    task automatic tick();
        logic s1, s0, h1;
        logic [DW-1:0] w1;
        if1.fifo_empty = (q1.size() == 0);
        if0.fifo_empty = (q0.size() == 0);
        if0.fifo_dout  = (q0.size() != 0) ? q0[0] : '0;
        #1;
        s1 = if1.fifo_shift_out; s0 = if0.fifo_shift_out;
        w1 = if1.fifo_dout; h1 = 1'b0;
        if (if1.m_valid && if1.m_ready) begin
            got1.push_back(if1.m_data); beat_cyc1.push_back(cyc);
            // With nothing pending, record a value that cannot match the beat.
            want1.push_back(pend1.size() != 0 ? pend1.pop_front() : ~if1.m_data);
        end
        if (flush1) pend1.delete();
        if (s1) begin
            shift_cyc1.push_back(cyc);
            if (q1.size() != 0) begin w1 = q1.pop_front(); pend1.push_back(w1); h1 = 1'b1; end
        end
        if (pend1.size() > maxout1) maxout1 = pend1.size();
        if (if0.m_valid && if0.m_ready) begin
            got0.push_back(if0.m_data); beat_cyc0.push_back(cyc);
            want0.push_back(pend0.size() != 0 ? pend0.pop_front() : ~if0.m_data);
        end
        if (flush0) pend0.delete();
        if (s0) begin
            shift_cyc0.push_back(cyc);
            if (q0.size() != 0) pend0.push_back(q0.pop_front());
        end
        if (pend0.size() > maxout0) maxout0 = pend0.size();
        @(posedge clk); #1;
        cyc++;
        if1.fifo_valid = h1;
        if1.fifo_dout  = w1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        q1.push_back(32'h1); q0.push_back(32'h2);
        if1.fifo_empty = 1'b0; if0.fifo_empty = 1'b0; if0.fifo_dout = 32'h2;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({if1.m_valid, if1.fifo_shift_out, pe1, lv1, bc1, if1.m_data} !== '0) begin
            failures++;
            $display("FAIL reset_lat1: got v=%b so=%b err=%b lvl=%0d bc=%0d data=%0h, required all 0",
                     if1.m_valid, if1.fifo_shift_out, pe1, lv1, bc1, if1.m_data);
        end
        checks++;
        if ({if0.m_valid, if0.fifo_shift_out, pe0, lv0, bc0, if0.m_data} !== '0) begin
            failures++;
            $display("FAIL reset_lat0: got v=%b so=%b err=%b lvl=%0d bc=%0d data=%0h, required all 0",
                     if0.m_valid, if0.fifo_shift_out, pe0, lv0, bc0, if0.m_data);
        end
        q1.delete(); q0.delete();
        rst_n = 1'b1;
        repeat (2) tick();
        clear_rec();
    endtask

    task automatic test_streaming();
        clear_rec();
        for (int i = 0; i < 8; i++) q1.push_back(DW'(32'h10 + i));
        if1.m_ready = 1'b1;
        for (int i = 0; i < 40 && got1.size() < 8; i++) tick();
        repeat (3) tick();
        checks++;
        if (got1.size() != 8) begin
            failures++; $display("FAIL stream_count: got %0d beats, required 8", got1.size());
        end
        for (int i = 0; i < 8 && i < got1.size(); i++) begin
            checks++;
            if (got1[i] !== DW'(32'h10 + i)) begin
                failures++; $display("FAIL stream_data[%0d]: got %0h required %0h", i, got1[i], 32'h10 + i);
            end
        end
        if (got1.size() == 8 && shift_cyc1.size() != 0) begin
            checks++;
            if (beat_cyc1[7] - beat_cyc1[0] != 7) begin
                failures++; $display("FAIL stream_consecutive: got span %0d required 7", beat_cyc1[7] - beat_cyc1[0]);
            end
            checks++;
            if (beat_cyc1[0] - shift_cyc1[0] != 2) begin
                failures++; $display("FAIL stream_latency: got %0d required 2", beat_cyc1[0] - shift_cyc1[0]);
            end
        end
        checks++;
        if (bc1 !== 32'd8) begin
            failures++; $display("FAIL stream_beat_count: got %0d required 8", bc1);
        end
    endtask

    task automatic test_backpressure();
        bit moved = 0;
        clear_rec();
        if1.m_ready = 1'b0;
        for (int i = 0; i < 6; i++) q1.push_back(DW'(32'h10 + i));
        repeat (10) begin
            tick();
            if (if1.m_valid && if1.m_data !== 32'h10) moved = 1;
        end
        checks++;
        if (shift_cyc1.size() != 2) begin
            failures++; $display("FAIL bp_pops: got %0d required 2", shift_cyc1.size());
        end
        checks++;
        if (lv1 !== LW'(2)) begin
            failures++; $display("FAIL bp_level: got %0d required 2", lv1);
        end
        checks++;
        if (if1.m_data !== 32'h10 || moved) begin
            failures++; $display("FAIL bp_hold: got %0h (moved=%0d) required 10", if1.m_data, moved);
        end
        if1.m_ready = 1'b1;
        for (int i = 0; i < 30 && got1.size() < 6; i++) tick();
        repeat (4) tick();
        checks++;
        if (got1.size() != 6) begin
            failures++; $display("FAIL bp_count: got %0d beats required 6", got1.size());
        end
        for (int i = 0; i < 6 && i < got1.size(); i++) begin
            checks++;
            if (got1[i] !== DW'(32'h10 + i)) begin
                failures++; $display("FAIL bp_data[%0d]: got %0h required %0h", i, got1[i], 32'h10 + i);
            end
        end
        checks++;
        if (bc1 !== 32'd14) begin
            failures++; $display("FAIL bp_beat_count: got %0d required 14", bc1);
        end
    endtask

    task automatic test_empty();
        clear_rec();
        if1.m_ready = 1'b1;
        repeat (6) tick();
        checks++;
        if (shift_cyc1.size() != 0 || got1.size() != 0 || if1.m_valid !== 1'b0 || pe1 !== 1'b0) begin
            failures++;
            $display("FAIL empty_idle: got pops=%0d beats=%0d valid=%b err=%b required 0 0 0 0",
                     shift_cyc1.size(), got1.size(), if1.m_valid, pe1);
        end
        q1.push_back(32'hAB);
        for (int i = 0; i < 10 && got1.size() < 1; i++) tick();
        repeat (4) tick();
        checks++;
        if (got1.size() != 1 || (got1.size() == 1 && got1[0] !== 32'hAB)) begin
            failures++;
            $display("FAIL empty_single: got %0d beats first=%0h required 1 beat AB",
                     got1.size(), got1.size() != 0 ? got1[0] : 32'h0);
        end
    endtask

    task automatic test_flush();
        logic [DW-1:0] nxt;
        int g0, base;
        bit found = 0;
        clear_rec();
        base = bc1;
        if1.m_ready = 1'b1;
        for (int i = 0; i < 6; i++) q1.push_back(DW'(32'h30 + i));
        for (int i = 0; i < 10 && !found; i++) begin
            if1.fifo_empty = (q1.size() == 0);
            #1;
            if (lv1 == LW'(1) && if1.fifo_shift_out) found = 1;
            else tick();
        end
        checks++;
        if (!found) begin
            failures++; $display("FAIL flush_setup: got no cycle with level 1 and a pop, required one");
        end
        tick();
        flush1 = 1'b1;
        nxt = q1[0];
        tick();
        flush1 = 1'b0;
        checks++;
        if (if1.m_valid !== 1'b0 || lv1 !== '0) begin
            failures++; $display("FAIL flush_clear: got valid=%b level=%0d required 0 0", if1.m_valid, lv1);
        end
        g0 = got1.size();
        for (int i = 0; i < 10 && got1.size() <= g0; i++) tick();
        checks++;
        if (got1.size() <= g0 || got1[g0] !== nxt) begin
            failures++;
            $display("FAIL flush_next: got %0h required %0h", got1.size() > g0 ? got1[g0] : 32'h0, nxt);
        end
        repeat (12) tick();
        for (int i = 0; i < got1.size(); i++) begin
            checks++;
            if (got1[i] !== want1[i]) begin
                failures++; $display("FAIL flush_order[%0d]: got %0h required %0h", i, got1[i], want1[i]);
            end
        end
        checks++;
        if (bc1 - base != got1.size() || pe1 !== 1'b0) begin
            failures++; $display("FAIL flush_count: got %0d beats err=%b required %0d err=0", bc1 - base, pe1, got1.size());
        end
    endtask

    task automatic test_latency0();
        clear_rec();
        if0.m_ready = 1'b1;
        q0.push_back(32'd1); q0.push_back(32'd2); q0.push_back(32'd3);
        for (int i = 0; i < 20 && got0.size() < 3; i++) tick();
        repeat (3) tick();
        checks++;
        if (got0.size() != 3) begin
            failures++; $display("FAIL lat0_count: got %0d beats required 3", got0.size());
        end
        for (int i = 0; i < 3 && i < got0.size() && i < shift_cyc0.size(); i++) begin
            checks++;
            if (got0[i] !== DW'(i + 1) || beat_cyc0[i] - shift_cyc0[i] != 1) begin
                failures++;
                $display("FAIL lat0_beat[%0d]: got %0h after %0d cycles required %0h after 1",
                         i, got0[i], beat_cyc0[i] - shift_cyc0[i], i + 1);
            end
        end
        checks++;
        if (bc0 !== 32'd3) begin
            failures++; $display("FAIL lat0_beat_count: got %0d required 3", bc0);
        end
    endtask

    task automatic test_random();
        int base1, base0;
        clear_rec();
        base1 = bc1; base0 = bc0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) q1.push_back($urandom);
            if ($urandom_range(0, 2) == 0) q0.push_back($urandom);
            if1.m_ready = ($urandom_range(0, 9) < 7);
            if0.m_ready = ($urandom_range(0, 9) < 6);
            flush1 = ($urandom_range(0, 29) == 0);
            flush0 = ($urandom_range(0, 29) == 0);
            tick();
        end
        flush1 = 1'b0; flush0 = 1'b0;
        if1.m_ready = 1'b1; if0.m_ready = 1'b1;
        for (int i = 0; i < 400 && (q1.size() + q0.size() + pend1.size() + pend0.size()) != 0; i++) tick();
        repeat (3) tick();
        for (int i = 0; i < got1.size(); i++) begin
            checks++;
            if (got1[i] !== want1[i]) begin
                failures++; $display("FAIL rand_lat1[%0d]: got %0h required %0h", i, got1[i], want1[i]);
            end
        end
        for (int i = 0; i < got0.size(); i++) begin
            checks++;
            if (got0[i] !== want0[i]) begin
                failures++; $display("FAIL rand_lat0[%0d]: got %0h required %0h", i, got0[i], want0[i]);
            end
        end
        checks++;
        if (maxout1 > BD || maxout0 > BD || pend1.size() != 0 || pend0.size() != 0) begin
            failures++;
            $display("FAIL rand_credit: got max outstanding %0d/%0d left %0d/%0d required <=%0d and 0 left",
                     maxout1, maxout0, pend1.size(), pend0.size(), BD);
        end
        checks++;
        if (bc1 - base1 != got1.size() || bc0 - base0 != got0.size() || pe1 !== 1'b0 || pe0 !== 1'b0) begin
            failures++;
            $display("FAIL rand_counts: got bc %0d/%0d err %b/%b required %0d/%0d err 0/0",
                     bc1 - base1, bc0 - base0, pe1, pe0, got1.size(), got0.size());
        end
    endtask

    task automatic test_protocol_err();
        repeat (3) tick();
        if1.fifo_valid = 1'b1;
        if1.fifo_dout  = 32'hEE;
        force0 = 1'b1;
        tick();
        force0 = 1'b0;
        checks++;
        if (pe1 !== 1'b1 || lv1 !== '0 || if1.m_valid !== 1'b0) begin
            failures++; $display("FAIL perr_lat1: got err=%b level=%0d valid=%b required 1 0 0", pe1, lv1, if1.m_valid);
        end
        checks++;
        if (pe0 !== 1'b1 || lv0 !== '0) begin
            failures++; $display("FAIL perr_lat0: got err=%b level=%0d required 1 0", pe0, lv0);
        end
        repeat (5) tick();
        checks++;
        if (pe1 !== 1'b1 || pe0 !== 1'b1) begin
            failures++; $display("FAIL perr_sticky: got %b/%b required 1/1", pe1, pe0);
        end
    endtask

    task automatic test_async_reset();
        clear_rec();
        if1.m_ready = 1'b1;
        for (int i = 0; i < 20; i++) q1.push_back(DW'(32'h100 + i));
        repeat (6) tick();
        checks++;
        if (if1.m_valid !== 1'b1) begin
            failures++; $display("FAIL areset_pre: got valid=%b required 1", if1.m_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({if1.m_valid, if1.fifo_shift_out, pe1, lv1, bc1, if1.m_data} !== '0
            || {if0.m_valid, pe0, bc0} !== '0) begin
            failures++;
            $display("FAIL areset_now: got v=%b so=%b err=%b/%b lvl=%0d bc=%0d data=%0h required all 0",
                     if1.m_valid, if1.fifo_shift_out, pe1, pe0, lv1, bc1, if1.m_data);
        end
        q1.delete(); q0.delete();
        if1.fifo_valid = 1'b0; if1.fifo_empty = 1'b1; if0.fifo_empty = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) tick();
    endtask

    initial begin
        if1.m_ready = 1'b0; if0.m_ready = 1'b0;
        if1.fifo_valid = 1'b0; if1.fifo_dout = '0; if1.fifo_empty = 1'b1;
        if0.fifo_empty = 1'b1; if0.fifo_dout = '0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_empty();
        test_flush();
        test_latency0();
        test_random();
        test_protocol_err();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
